// File: rtl/dac_scheduler.sv
// dac_scheduler
//   Shares one DAC serial interface between two sample requesters (A and B).
//   A round-robin grant latches the winner's sample onto dac_data, pulses
//   dac_start, waits for dac_done (or a timeout), acknowledges the winner and
//   then holds off for MIN_GAP idle cycles before the next grant.
//
// Ports
//   sclk         in   clock, all logic on the rising edge
//   reset        in   synchronous active-high reset
//   req_a/req_b  in   transfer request, held with its data until acknowledged
//   data_a/b     in   sample words, captured only at grant
//   ack_a/ack_b  out  one-cycle pulse when the granted sample has completed
//   dac_data     out  sample presented to the DAC, held until the next grant
//   dac_start    out  one-cycle pulse starting a DAC transfer
//   dac_done     in   DAC finished the current transfer (ignored outside WAIT)
//   busy         out  high whenever the scheduler is not idle
//   last_grant   out  0 = A granted last, 1 = B granted last
//   timeout_err  out  sticky flag: a transfer timed out, cleared only by reset
module dac_scheduler #(
  parameter int DATA_W  = 8,
  parameter int MIN_GAP = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              sclk,
  input  logic              reset,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_start,
  input  logic              dac_done,
  output logic              busy,
  output logic              last_grant,
  output logic              timeout_err
);

  // One counter serves both the WAIT timeout and the GAP hold-off, so it is
  // sized for the larger of the two; neither state lets it run past its limit.
  localparam int CNT_MAX = (TIMEOUT > MIN_GAP) ? TIMEOUT : MIN_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = (MIN_GAP > 0) ? CNT_W'(MIN_GAP - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_dac_data;
  logic              r_last_grant;
  logic              r_ack_a;
  logic              r_ack_b;
  logic              r_timeout_err;

  logic              w_any_req;
  logic              w_win_b;
  logic              w_done_ok;
  logic              w_timeout;
  logic              w_dac_start;
  logic              w_busy;

  assign w_any_req = req_a | req_b;
  // On a tie the side that did not win last time gets the grant.
  assign w_win_b   = req_b & (~req_a | ~r_last_grant);
  assign w_done_ok = (r_state == S_WAIT) & dac_done;
  // dac_done on the final WAIT cycle takes priority over the timeout.
  assign w_timeout = (r_state == S_WAIT) & ~dac_done & (r_cnt == TO_LAST);

  always_ff @(posedge sclk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_dac_start = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_any_req) w_next = S_START;
      end
      S_START: begin
        w_dac_start = 1'b1;
        w_next      = S_WAIT;
      end
      S_WAIT: begin
        if (w_done_ok | w_timeout) w_next = (MIN_GAP == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_WAIT:  r_cnt <= (w_done_ok | w_timeout) ? '0 : r_cnt + 1'b1;
        S_GAP:   r_cnt <= r_cnt + 1'b1;
        default: r_cnt <= '0;
      endcase
    end
  end

  // Grant capture: winner's sample and identity are latched in IDLE.
  always_ff @(posedge sclk) begin
    if (reset) begin
      r_dac_data   <= '0;
      r_last_grant <= 1'b1;
    end else if ((r_state == S_IDLE) && w_any_req) begin
      r_dac_data   <= w_win_b ? data_b : data_a;
      r_last_grant <= w_win_b;
    end
  end

  // Acknowledge goes to the side recorded at grant; a timeout gives no ack.
  always_ff @(posedge sclk) begin
    if (reset) begin
      r_ack_a       <= 1'b0;
      r_ack_b       <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_ack_a <= w_done_ok & ~r_last_grant;
      r_ack_b <= w_done_ok &  r_last_grant;
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign ack_a       = r_ack_a;
  assign ack_b       = r_ack_b;
  assign dac_data    = r_dac_data;
  assign dac_start   = w_dac_start;
  assign busy        = w_busy;
  assign last_grant  = r_last_grant;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_dac_scheduler.sv
// Randomized bench for dac_scheduler. The reference model works on
// transaction timestamps: the cycle of each grant's dac_start, the cycle the
// transfer finishes, the cycle its ack is due and the first cycle the
// scheduler is free again.
module tb_dac_scheduler;

  localparam int DATA_W  = 8;
  localparam int MIN_GAP = 3;
  localparam int TIMEOUT = 12;
  localparam int NCYC    = 6000;
  localparam int NEVER   = 32'h7fff_ffff;

  logic              sclk = 1'b0;
  logic              reset = 1'b1;
  logic              req_a = 1'b0;
  logic              req_b = 1'b0;
  logic [DATA_W-1:0] data_a = '0;
  logic [DATA_W-1:0] data_b = '0;
  logic              dac_done = 1'b0;
  logic              ack_a, ack_b, dac_start, busy, last_grant, timeout_err;
  logic [DATA_W-1:0] dac_data;

  dac_scheduler #(.DATA_W(DATA_W), .MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT)) dut (
    .sclk(sclk), .reset(reset),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .dac_data(dac_data), .dac_start(dac_start), .dac_done(dac_done),
    .busy(busy), .last_grant(last_grant), .timeout_err(timeout_err)
  );

  always #5 sclk = ~sclk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  // Reference model state
  int                m_t0      = -10;   // cycle in which dac_start is due
  int                m_free    = 0;     // first cycle the scheduler is idle
  int                m_ack_cyc = -10;   // cycle in which an ack is due
  bit                m_ack_b   = 1'b0;
  bit                m_pending = 1'b0;  // transfer started, end not yet seen
  bit                m_owner   = 1'b0;
  bit                m_last    = 1'b1;
  bit                m_err     = 1'b0;
  logic [DATA_W-1:0] m_data    = '0;

  int done_at = -10;
  int n_timeouts = 0;
  int n_acks = 0;

  initial begin
    bit win_b;
    @(posedge sclk);
    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge sclk);

      // Compare outputs visible in this cycle with the model
      chk("busy",        busy,        cyc < m_free);
      chk("dac_start",   dac_start,   cyc == m_t0);
      chk("ack_a",       ack_a,       (cyc == m_ack_cyc) && !m_ack_b);
      chk("ack_b",       ack_b,       (cyc == m_ack_cyc) &&  m_ack_b);
      chk("dac_data",    dac_data,    m_data);
      chk("last_grant",  last_grant,  m_last);
      chk("timeout_err", timeout_err, m_err);

      // Requester A
      if ((cyc == m_ack_cyc) && !m_ack_b) begin
        if ($urandom_range(1, 0) == 0) req_a = 1'b0;
        else data_a = DATA_W'($urandom);
      end else if (!req_a && ($urandom_range(3, 0) == 0)) begin
        req_a  = 1'b1;
        data_a = DATA_W'($urandom);
      end
      // Requester B
      if ((cyc == m_ack_cyc) && m_ack_b) begin
        if ($urandom_range(1, 0) == 0) req_b = 1'b0;
        else data_b = DATA_W'($urandom);
      end else if (!req_b && ($urandom_range(3, 0) == 0)) begin
        req_b  = 1'b1;
        data_b = DATA_W'($urandom);
      end

      // DAC responder: pick a completion delay at each start, biased towards
      // the timeout boundary and never-completing transfers.
      if (cyc == m_t0) begin
        case ($urandom_range(4, 0))
          0:       done_at = m_t0 + TIMEOUT + 5;
          1:       done_at = m_t0 + TIMEOUT;
          2:       done_at = m_t0 + TIMEOUT - 1;
          default: done_at = m_t0 + int'($urandom_range(TIMEOUT - 2, 1));
        endcase
      end
      dac_done = (cyc == done_at);
      if (!(m_pending && (cyc > m_t0)) && ($urandom_range(5, 0) == 0)) dac_done = 1'b1;

      reset = (cyc < 3) || ($urandom_range(249, 0) == 0);

      // Model: what the upcoming clock edge does with these inputs
      if (reset) begin
        m_pending = 1'b0;
        m_free    = cyc + 1;
        m_t0      = -10;
        m_ack_cyc = -10;
        m_err     = 1'b0;
        m_last    = 1'b1;
        m_data    = '0;
      end else if (cyc >= m_free) begin
        if (req_a || req_b) begin
          win_b     = (req_a && req_b) ? !m_last : req_b;
          m_owner   = win_b;
          m_last    = win_b;
          m_data    = win_b ? data_b : data_a;
          m_t0      = cyc + 1;
          m_free    = NEVER;
          m_pending = 1'b1;
        end
      end else if (m_pending && (cyc > m_t0)) begin
        if (dac_done) begin
          m_ack_cyc = cyc + 1;
          m_ack_b   = m_owner;
          m_pending = 1'b0;
          m_free    = cyc + MIN_GAP + 1;
          n_acks++;
        end else if (cyc - m_t0 == TIMEOUT) begin
          m_err     = 1'b1;
          m_pending = 1'b0;
          m_free    = cyc + MIN_GAP + 1;
          n_timeouts++;
        end
      end
    end

    $display("transfers acked=%0d timed_out=%0d", n_acks, n_timeouts);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
